ram_port_master: RTL

//   Command-side initiator for single_port_BRAM. Accepts read/write commands on a

---
 rtl/ram_port_master_if.sv | 49 ++++
 rtl/ram_port_master.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ram_port_master_if.sv
// Bundle of the command, response and RAM-pin signals of ram_port_master.
// The master modport is the block itself; the slave modport is the agent/RAM side.
interface ram_port_master_if #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 32,
   parameter int LEN_WIDTH     = 4
);

   logic                     cmd_valid;
   logic                     cmd_ready;
   logic                     cmd_write;
   logic [ADDRESS_WIDTH-1:0] cmd_addr;
   logic [LEN_WIDTH-1:0]     cmd_len;
   logic [DATA_WIDTH-1:0]    cmd_wdata;

   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [DATA_WIDTH-1:0]    rsp_data;
   logic                     rsp_last;

   logic                     ram_read_en;
   logic                     ram_write_en;
   logic [ADDRESS_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0]    ram_data_in;
   logic [DATA_WIDTH-1:0]    ram_data_out;

   logic                     busy;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_wdata,
      output cmd_ready,
      output rsp_valid, rsp_data, rsp_last,
      input  rsp_ready,
      output ram_read_en, ram_write_en, ram_addr, ram_data_in,
      input  ram_data_out,
      output busy
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_wdata,
      input  cmd_ready,
      input  rsp_valid, rsp_data, rsp_last,
      output rsp_ready,
      input  ram_read_en, ram_write_en, ram_addr, ram_data_in,
      output ram_data_out,
      input  busy
   );

endinterface

// File: rtl/ram_port_master.sv
// Command-side initiator for a single-port RAM: valid/ready commands in, RAM pins out,
// registered read responses back. Define RAM_PORT_BURST_EN to honour cmd_len bursts.
module ram_port_master #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 32,
   parameter int LEN_WIDTH     = 4
) (
   input logic               clk,
   input logic               clr,
   ram_port_master_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]     cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]    rsp_data_q, rsp_data_d;
   logic                     rsp_valid_q, rsp_valid_d;
   logic                     rsp_last_q, rsp_last_d;

   logic [LEN_WIDTH-1:0]     cmd_len_eff;
   logic                     cnt_zero;
   logic                     rsp_taken;
   logic                     read_beat;
   logic                     cmd_ready_c;
   logic                     ram_write_en_c;
   logic [DATA_WIDTH-1:0]    ram_data_in_c;

`ifdef RAM_PORT_BURST_EN
   assign cmd_len_eff = bus.cmd_len;
`else
   assign cmd_len_eff = '0;
`endif

   assign cnt_zero  = (cnt_q == '0);
   assign rsp_taken = rsp_valid_q && bus.rsp_ready;
   // A read beat may issue whenever the response register is free or being emptied this edge.
   assign read_beat = (state_q == READ) && (!rsp_valid_q || bus.rsp_ready);

   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      cnt_d          = cnt_q;
      wdata_d        = wdata_q;
      rsp_data_d     = rsp_data_q;
      rsp_valid_d    = rsp_valid_q;
      rsp_last_d     = rsp_last_q;
      cmd_ready_c    = 1'b0;
      ram_write_en_c = 1'b0;
      ram_data_in_c  = '0;

      if (rsp_taken) begin
         rsp_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            cmd_ready_c = 1'b1;
            if (bus.cmd_valid) begin
               addr_d  = bus.cmd_addr;
               cnt_d   = cmd_len_eff;
               wdata_d = bus.cmd_wdata;
               state_d = bus.cmd_write ? WRITE : READ;
            end
         end

         WRITE: begin
            ram_write_en_c = 1'b1;
            ram_data_in_c  = wdata_q;
            addr_d         = addr_q + 1'b1;
            if (cnt_zero) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         READ: begin
            if (read_beat) begin
               rsp_data_d  = bus.ram_data_out;
               rsp_valid_d = 1'b1;
               rsp_last_d  = cnt_zero;
               addr_d      = addr_q + 1'b1;
               if (cnt_zero) begin
                  state_d = DRAIN;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end

         DRAIN: begin
            if (rsp_taken) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         cnt_q       <= '0;
         wdata_q     <= '0;
         rsp_data_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         wdata_q     <= wdata_d;
         rsp_data_q  <= rsp_data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_last_q  <= rsp_last_d;
      end
   end

   assign bus.cmd_ready    = cmd_ready_c;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_data     = rsp_data_q;
   assign bus.rsp_last     = rsp_last_q;
   assign bus.ram_read_en  = read_beat;
   assign bus.ram_write_en = ram_write_en_c;
   assign bus.ram_addr     = addr_q;
   assign bus.ram_data_in  = ram_data_in_c;
   assign bus.busy         = (state_q != IDLE);

endmodule
